// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, state encoding and requester indices for the register-file write port
// Contents: DATA_W, ADDR_W, NREG, ZERO_REG, state_t {CLEAR, RUN}, REQ_A, REQ_B.
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/regfile_wr_ctrl_if.sv
// rtl/regfile_wr_ctrl_if.sv - requester A/B valid/ready write handshakes
// Ports (signals): a_valid/a_addr/a_data and b_valid/b_addr/b_data driven by the requesters,
// a_ready/b_ready returned by the write controller.
interface regfile_wr_ctrl_if;
    import regfile_pkg::*;

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with accept-qualified pointer update
// Ports: clk, rst_n (async active-low), valid[1:0] requests, accept (grant was taken this cycle),
// grant[1:0] one-hot combinational grant.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);
    // ptr_q names the requester that wins a tie.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Priority moves to the other requester only when a transfer actually happens,
    // so a stalled pair keeps its order.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && (grant != 2'b00)) begin
            ptr_d = grant[REQ_A] ? REQ_B : REQ_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/regfile_wr_ctrl.sv
// rtl/regfile_wr_ctrl.sv - register-file write-port controller: clear sequencer plus A/B round-robin writeback
// Ports: clk, rst_n (async active-low), req (slave modport: A/B valid/ready/addr/data),
// clr_start (re-clear request), busy (clear in progress), clr_done (pulse on last clear write),
// wr_en/wr_addr/wr_data (registered register-file write port).
module regfile_wr_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    regfile_wr_ctrl_if.slave  req,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              clr_done_q, clr_done_d;

    logic [1:0]        grant;
    logic              can_accept;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // A clear command in RUN takes the cycle, so nothing is accepted alongside it.
    assign can_accept = (state_q == RUN) && !clr_start;
    assign accept     = can_accept && (grant != 2'b00);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  ({req.b_valid, req.a_valid}),
        .accept (accept),
        .grant  (grant)
    );

    assign req.a_ready = can_accept && grant[REQ_A];
    assign req.b_ready = can_accept && grant[REQ_B];

    assign sel_addr = grant[REQ_B] ? req.b_addr : req.a_addr;
    assign sel_data = grant[REQ_B] ? req.b_data : req.a_data;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        clr_done_d = 1'b0;
        case (state_q)
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = '0;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_REG) begin
                    state_d    = RUN;
                    clr_done_d = 1'b1;
                end
            end
            RUN: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = FIRST_REG;
                end else if (accept) begin
                    // Register 0 is hard-wired zero: accept the handshake, suppress the write.
                    wr_en_d   = (sel_addr != ZERO_REG);
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = FIRST_REG;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            cnt_q      <= FIRST_REG;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_done = clr_done_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
endmodule
